// File: rtl/serial_adder_pkg.sv
// Shared definitions for the digit-serial adder: state encoding and sizing helpers.
// The bench imports this package so it compares against the same encoding as the RTL.
package serial_adder_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    RUN  = ST_RUN,
    DONE = ST_DONE
  } state_t;

  // The digit counter must be able to hold the value ndig.
  function automatic int cnt_width(input int ndig);
    return $clog2(ndig + 1);
  endfunction

endpackage

// File: rtl/serial_adder_full_adder.sv
// 1-bit full adder cell; chained to build one digit of the serial adder.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic sum,
  output logic carry
);

  assign sum   = a ^ b ^ c;
  assign carry = (a & b) | (a & c) | (b & c);

endmodule

// File: rtl/serial_adder.sv
// Digit-serial adder: adds DIGIT_W bits per clock, LSB digit first, carry kept in a register.
// Handshake: start is accepted in IDLE or DONE; busy is high throughout RUN; done pulses for one cycle once sum/cout/ovf are updated.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int DIGIT_W = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output state_t           fsm_state
);

  localparam int NDIG = (DIGIT_W > 0) ? WIDTH / DIGIT_W : 1;
  localparam int CW   = cnt_width(NDIG);
  localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

  if (DIGIT_W < 1 || WIDTH < 1 || (WIDTH % DIGIT_W) != 0) begin : g_bad_params
    $error("serial_adder: WIDTH must be a nonzero multiple of DIGIT_W");
  end

  state_t           state;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic [WIDTH-1:0] res;
  logic [WIDTH-1:0] res_next;
  logic [DIGIT_W-1:0] dsum;
  logic             dcarry;
  logic             msb_cin;

  // Ripple chain inside one digit; each stage owns its carry signals.
  for (genvar i = 0; i < DIGIT_W; i++) begin : g_fa
    logic ci;
    logic co;
    if (i == 0) begin : g_first
      assign ci = carry;
    end else begin : g_next
      assign ci = g_fa[i-1].co;
    end
    full_adder u_fa (
      .a     (opa[i]),
      .b     (opb[i]),
      .c     (ci),
      .sum   (dsum[i]),
      .carry (co)
    );
  end

  assign dcarry  = g_fa[DIGIT_W-1].co;
  assign msb_cin = g_fa[DIGIT_W-1].ci;

  // New digits enter at the top so the first digit ends up at bit 0.
  if (NDIG == 1) begin : g_res_single
    assign res_next = dsum;
  end else begin : g_res_shift
    assign res_next = {dsum, res[WIDTH-1:DIGIT_W]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      carry <= 1'b0;
      opa   <= '0;
      opb   <= '0;
      res   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            opa   <= a;
            opb   <= b;
            carry <= cin;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          res   <= res_next;
          carry <= dcarry;
          opa   <= opa >> DIGIT_W;
          opb   <= opb >> DIGIT_W;
          cnt   <= cnt + CW'(1);
          if (cnt == LAST) begin
            sum   <= res_next;
            cout  <= dcarry;
            ovf   <= dcarry ^ msb_cin;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  assign fsm_state = state;

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: three configurations (8/1, 8/4, 4/1) with directed vectors,
// an exhaustive 4-bit sweep, back-to-back/mid-run start, and reset abort.
module tb_serial_adder;
  import serial_adder_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;

  // WIDTH=8, DIGIT_W=1
  logic       u8_start, u8_cin, u8_busy, u8_done, u8_cout, u8_ovf;
  logic [7:0] u8_a, u8_b, u8_sum;
  state_t     u8_state;
  // WIDTH=8, DIGIT_W=4
  logic       u84_start, u84_cin, u84_busy, u84_done, u84_cout, u84_ovf;
  logic [7:0] u84_a, u84_b, u84_sum;
  state_t     u84_state;
  // WIDTH=4, DIGIT_W=1
  logic       u4_start, u4_cin, u4_busy, u4_done, u4_cout, u4_ovf;
  logic [3:0] u4_a, u4_b, u4_sum;
  state_t     u4_state;

  serial_adder #(.WIDTH(8), .DIGIT_W(1)) dut8 (
    .clk(clk), .rst(rst), .start(u8_start), .a(u8_a), .b(u8_b), .cin(u8_cin),
    .busy(u8_busy), .done(u8_done), .sum(u8_sum), .cout(u8_cout), .ovf(u8_ovf),
    .fsm_state(u8_state)
  );
  serial_adder #(.WIDTH(8), .DIGIT_W(4)) dut84 (
    .clk(clk), .rst(rst), .start(u84_start), .a(u84_a), .b(u84_b), .cin(u84_cin),
    .busy(u84_busy), .done(u84_done), .sum(u84_sum), .cout(u84_cout), .ovf(u84_ovf),
    .fsm_state(u84_state)
  );
  serial_adder #(.WIDTH(4), .DIGIT_W(1)) dut4 (
    .clk(clk), .rst(rst), .start(u4_start), .a(u4_a), .b(u4_b), .cin(u4_cin),
    .busy(u4_busy), .done(u4_done), .sum(u4_sum), .cout(u4_cout), .ovf(u4_ovf),
    .fsm_state(u4_state)
  );

  // Expected {ovf, cout, sum} and the cycle on which done must be seen.
  logic [9:0] exp8_q[$];
  int         cyc8_q[$];
  logic [9:0] exp84_q[$];
  int         cyc84_q[$];
  logic [5:0] exp4_q[$];
  int         cyc4_q[$];
  int         done8_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s: event missing or unexpected (t=%0t)", name, $time);
  endtask

  // ---------------- scoreboard monitors ----------------
  always @(negedge clk) begin
    if (!rst) check("u8_busy_and_done", {31'd0, u8_busy & u8_done}, 0);
    if (u8_done) begin
      done8_cnt++;
      if (exp8_q.size() == 0) fail_now("u8_unexpected_done");
      else begin
        logic [9:0] e;
        int ec;
        e  = exp8_q.pop_front();
        ec = cyc8_q.pop_front();
        check("u8_sum",  u8_sum,  e[7:0]);
        check("u8_cout", u8_cout, e[8]);
        check("u8_ovf",  u8_ovf,  e[9]);
        check("u8_latency", cyc, ec);
      end
    end
  end

  always @(negedge clk) begin
    if (u84_done) begin
      if (exp84_q.size() == 0) fail_now("u84_unexpected_done");
      else begin
        logic [9:0] e;
        int ec;
        e  = exp84_q.pop_front();
        ec = cyc84_q.pop_front();
        check("u84_sum",  u84_sum,  e[7:0]);
        check("u84_cout", u84_cout, e[8]);
        check("u84_ovf",  u84_ovf,  e[9]);
        check("u84_latency", cyc, ec);
      end
    end
  end

  always @(negedge clk) begin
    if (u4_done) begin
      if (exp4_q.size() == 0) fail_now("u4_unexpected_done");
      else begin
        logic [5:0] e;
        int ec;
        e  = exp4_q.pop_front();
        ec = cyc4_q.pop_front();
        check("u4_sum",  u4_sum,  e[3:0]);
        check("u4_cout", u4_cout, e[4]);
        check("u4_ovf",  u4_ovf,  e[5]);
        check("u4_latency", cyc, ec);
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Called at a negedge; start is sampled on the following posedge.
  task automatic issue8(input logic [7:0] a, input logic [7:0] b, input logic cin,
                        input logic [9:0] exp);
    u8_a = a; u8_b = b; u8_cin = cin; u8_start = 1'b1;
    exp8_q.push_back(exp);
    cyc8_q.push_back(cyc + 1 + 8);
    @(negedge clk);
    u8_start = 1'b0;
    u8_a = 8'($urandom_range(0, 255));
    u8_b = 8'($urandom_range(0, 255));
    u8_cin = 1'($urandom_range(0, 1));
  endtask

  // Counts busy cycles until done; returns at the negedge inside the DONE cycle.
  task automatic wait8(input int exp_busy);
    int nb = 0;
    for (int i = 0; i < 20 && !u8_done; i++) begin
      if (u8_busy) nb++;
      @(negedge clk);
    end
    if (!u8_done) fail_now("u8_timeout");
    check("u8_busy_cycles", nb, exp_busy);
  endtask

  task automatic op84(input logic [7:0] a, input logic [7:0] b, input logic cin,
                      input logic [9:0] exp);
    int nb = 0;
    @(negedge clk);
    u84_a = a; u84_b = b; u84_cin = cin; u84_start = 1'b1;
    exp84_q.push_back(exp);
    cyc84_q.push_back(cyc + 1 + 2);
    @(negedge clk);
    u84_start = 1'b0;
    u84_a = 8'($urandom_range(0, 255));
    u84_b = 8'($urandom_range(0, 255));
    for (int i = 0; i < 10 && !u84_done; i++) begin
      if (u84_busy) nb++;
      @(negedge clk);
    end
    if (!u84_done) fail_now("u84_timeout");
    check("u84_busy_cycles", nb, 2);
  endtask

  task automatic op4(input logic [3:0] a, input logic [3:0] b, input logic cin,
                     input logic [5:0] exp);
    @(negedge clk);
    u4_a = a; u4_b = b; u4_cin = cin; u4_start = 1'b1;
    exp4_q.push_back(exp);
    cyc4_q.push_back(cyc + 1 + 4);
    @(negedge clk);
    u4_start = 1'b0;
    u4_a = 4'($urandom_range(0, 15));
    u4_b = 4'($urandom_range(0, 15));
    for (int i = 0; i < 10 && !u4_done; i++) @(negedge clk);
    if (!u4_done) fail_now("u4_timeout");
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int base;
    rst = 1'b1;
    u8_start = 0;  u8_a = 0;  u8_b = 0;  u8_cin = 0;
    u84_start = 0; u84_a = 0; u84_b = 0; u84_cin = 0;
    u4_start = 0;  u4_a = 0;  u4_b = 0;  u4_cin = 0;
    repeat (3) @(negedge clk);
    check("rst_u8_state", u8_state, ST_IDLE);
    check("rst_u8_busy",  u8_busy, 0);
    check("rst_u8_done",  u8_done, 0);
    check("rst_u8_sum",   u8_sum, 0);
    check("rst_u8_cout",  u8_cout, 0);
    check("rst_u8_ovf",   u8_ovf, 0);
    check("rst_u84_sum",  u84_sum, 0);
    check("rst_u4_state", u4_state, ST_IDLE);
    rst = 1'b0;
    @(negedge clk);

    // FF + 01: wraps to 00 with carry out, no signed overflow.
    issue8(8'hFF, 8'h01, 1'b0, {1'b0, 1'b1, 8'h00});
    check("u8_state_run", u8_state, ST_RUN);
    wait8(8);
    check("u8_state_done", u8_state, ST_DONE);
    @(negedge clk);
    check("u8_state_idle", u8_state, ST_IDLE);
    // 7F + 01: positive overflow into 80.
    issue8(8'h7F, 8'h01, 1'b0, {1'b1, 1'b0, 8'h80});
    wait8(8);
    @(negedge clk);
    // 80 + 80: negative overflow, carry out.
    issue8(8'h80, 8'h80, 1'b0, {1'b1, 1'b1, 8'h00});
    wait8(8);
    @(negedge clk);
    // 5A + 33 + 1 = 8E: signed overflow (90+51+1=142).
    issue8(8'h5A, 8'h33, 1'b1, {1'b1, 1'b0, 8'h8E});
    wait8(8);

    // Back-to-back: start while in DONE, then a start mid-RUN that must be ignored.
    issue8(8'h01, 8'h02, 1'b0, {1'b0, 1'b0, 8'h03});
    repeat (2) @(negedge clk);
    u8_a = 8'hFF; u8_b = 8'hFF; u8_cin = 1'b1; u8_start = 1'b1;
    @(negedge clk);
    u8_start = 1'b0;
    wait8(5);
    @(negedge clk);
    check("u8_sum_hold", u8_sum, 8'h03);

    // Reset after three RUN cycles abandons the operation.
    base = done8_cnt;
    u8_a = 8'hFF; u8_b = 8'h01; u8_cin = 1'b0; u8_start = 1'b1;
    @(negedge clk);
    u8_start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy",  u8_busy, 0);
    check("abort_done",  u8_done, 0);
    check("abort_sum",   u8_sum, 0);
    check("abort_state", u8_state, ST_IDLE);
    repeat (12) @(negedge clk);
    check("abort_no_done", done8_cnt, base);

    // DIGIT_W=4: two cycles per addition.
    op84(8'h3C, 8'hA5, 1'b1, {1'b0, 1'b0, 8'hE2});
    op84(8'hFF, 8'hFF, 1'b1, {1'b0, 1'b1, 8'hFF});
    op84(8'h7F, 8'h7F, 1'b0, {1'b1, 1'b0, 8'hFE});
    op84(8'h80, 8'hFF, 1'b0, {1'b1, 1'b1, 8'h7F});

    // Exhaustive 4-bit sweep against an integer reference.
    for (int ia = 0; ia < 16; ia++) begin
      for (int ib = 0; ib < 16; ib++) begin
        for (int ic = 0; ic < 2; ic++) begin
          int u, sa, sb, s;
          logic [5:0] e;
          u  = ia + ib + ic;
          sa = (ia >= 8) ? ia - 16 : ia;
          sb = (ib >= 8) ? ib - 16 : ib;
          s  = sa + sb + ic;
          e[3:0] = 4'(u);
          e[4]   = (u >= 16);
          e[5]   = (s > 7) || (s < -8);
          op4(4'(ia), 4'(ib), 1'(ic), e);
        end
      end
    end

    repeat (4) @(negedge clk);
    check("u8_queue_drained",  exp8_q.size(), 0);
    check("u84_queue_drained", exp84_q.size(), 0);
    check("u4_queue_drained",  exp4_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

endmodule
